// File: rtl/clk_reset_sequencer_if.sv
// rtl/clk_reset_sequencer_if.sv - refclk source select request channel (valid/ready)
interface clk_reset_sequencer_if;
    logic       clk_sel_valid;
    logic [1:0] clk_sel;
    logic       clk_sel_ready;

    modport master (
        output clk_sel_valid,
        output clk_sel,
        input  clk_sel_ready
    );

    modport slave (
        input  clk_sel_valid,
        input  clk_sel,
        output clk_sel_ready
    );
endinterface

// File: rtl/clk_reset_sequencer.sv
// rtl/clk_reset_sequencer.sv - DCM/GT bring-up, retry/fault and refclk reselect sequencer
module clk_reset_sequencer #(
    parameter int         LOCK_STABLE_CYCLES = 1024,
    parameter int         GT_RESET_CYCLES    = 16,
    parameter int         GT_LOCK_TIMEOUT    = 65535,
    parameter int         MAX_RETRIES        = 3,
    parameter logic [1:0] CLK_SET_DEFAULT    = 2'b00
) (
    input  logic                  drp_and_sys_clk,
    input  logic                  g_reset,
    input  logic                  dcm_locked,
    input  logic                  gt_pll_locked,
    clk_reset_sequencer_if.slave  sel_if,
    output logic                  sfp_mgt_clk_set0,
    output logic                  sfp_mgt_clk_set1,
    output logic                  gt_reset,
    output logic                  tx_reset,
    output logic                  link_ready,
    output logic                  seq_error,
    output logic [2:0]            seq_state
);
    typedef enum logic [2:0] {
        WAIT_DCM   = 3'd0,
        DCM_STABLE = 3'd1,
        GT_RST     = 3'd2,
        WAIT_GT    = 3'd3,
        RUN        = 3'd4,
        RECONFIG   = 3'd5,
        FAULT      = 3'd6
    } state_t;

    localparam logic [16:0] STABLE_LAST  = 17'(LOCK_STABLE_CYCLES - 1);
    localparam logic [16:0] GT_RST_LAST  = 17'(GT_RESET_CYCLES - 1);
    localparam logic [16:0] TIMEOUT_LAST = 17'(GT_LOCK_TIMEOUT - 1);
    localparam logic [16:0] RETRY_LIMIT  = 17'(MAX_RETRIES);

    state_t      state, state_d;
    logic [16:0] cnt, cnt_d, retry_cnt, retry_d;
    logic [1:0]  sel_cur, sel_cur_d, sel_req, sel_req_d;
    logic        sel_pend, sel_pend_d;
    logic        dcm_m, dcm_s, gt_m, gt_s;
    logic        accept, ready_q;
    logic        gt_reset_d, tx_reset_d, link_ready_d, seq_error_d, ready_d;

    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == 17'h1ffff) ? v : v + 17'd1;
    endfunction

    always_ff @(posedge drp_and_sys_clk) begin
        if (g_reset) begin
            dcm_m <= 1'b0;
            dcm_s <= 1'b0;
        end else begin
            dcm_m <= dcm_locked;
            dcm_s <= dcm_m;
        end
    end

    // A lock seen while the GT is held in reset is stale, so qualify only after release.
    always_ff @(posedge drp_and_sys_clk) begin
        if (g_reset || gt_reset) begin
            gt_m <= 1'b0;
            gt_s <= 1'b0;
        end else begin
            gt_m <= gt_pll_locked;
            gt_s <= gt_m;
        end
    end

    always_ff @(posedge drp_and_sys_clk) begin
        if (g_reset) begin
            state      <= WAIT_DCM;
            cnt        <= '0;
            retry_cnt  <= '0;
            sel_cur    <= CLK_SET_DEFAULT;
            sel_req    <= CLK_SET_DEFAULT;
            sel_pend   <= 1'b0;
            gt_reset   <= 1'b1;
            tx_reset   <= 1'b1;
            link_ready <= 1'b0;
            seq_error  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            retry_cnt  <= retry_d;
            sel_cur    <= sel_cur_d;
            sel_req    <= sel_req_d;
            sel_pend   <= sel_pend_d;
            gt_reset   <= gt_reset_d;
            tx_reset   <= tx_reset_d;
            link_ready <= link_ready_d;
            seq_error  <= seq_error_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        retry_d    = retry_cnt;
        sel_cur_d  = sel_cur;
        sel_req_d  = sel_req;
        sel_pend_d = sel_pend;
        accept     = sel_if.clk_sel_valid && ready_q;
        // An accepted change stays pending if a DCM loss pre-empts the reconfigure.
        if (accept) begin
            sel_req_d  = sel_if.clk_sel;
            sel_pend_d = (sel_if.clk_sel != sel_cur);
        end
        case (state)
            WAIT_DCM: begin
                cnt_d = '0;
                if (dcm_s) state_d = DCM_STABLE;
            end
            FAULT: cnt_d = '0;
            default: begin
                if (!dcm_s) begin
                    state_d = WAIT_DCM;
                    cnt_d   = '0;
                end else begin
                    case (state)
                        DCM_STABLE: begin
                            if (cnt == STABLE_LAST) begin
                                state_d = GT_RST;
                                cnt_d   = '0;
                            end else cnt_d = sat_inc(cnt);
                        end
                        GT_RST: begin
                            if (cnt == GT_RST_LAST) begin
                                state_d = WAIT_GT;
                                cnt_d   = '0;
                            end else cnt_d = sat_inc(cnt);
                        end
                        WAIT_GT: begin
                            if (gt_s) begin
                                state_d = RUN;
                                cnt_d   = '0;
                                retry_d = '0;
                            end else if (cnt >= TIMEOUT_LAST) begin
                                cnt_d   = '0;
                                retry_d = sat_inc(retry_cnt);
                                state_d = (retry_d >= RETRY_LIMIT) ? FAULT : GT_RST;
                            end else cnt_d = sat_inc(cnt);
                        end
                        RUN: begin
                            if (!gt_s) begin
                                state_d = GT_RST;
                                cnt_d   = '0;
                                retry_d = sat_inc(retry_cnt);
                            end else if (sel_pend_d) begin
                                state_d = RECONFIG;
                            end
                        end
                        RECONFIG: begin
                            state_d = GT_RST;
                            cnt_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        if (state_d == RECONFIG && state != RECONFIG) begin
            sel_cur_d  = sel_req_d;
            sel_pend_d = 1'b0;
        end
    end

    always_comb begin
        gt_reset_d   = 1'b1;
        tx_reset_d   = 1'b1;
        link_ready_d = 1'b0;
        seq_error_d  = 1'b0;
        ready_d      = 1'b0;
        case (state_d)
            WAIT_GT: gt_reset_d = 1'b0;
            RUN: begin
                gt_reset_d   = 1'b0;
                tx_reset_d   = 1'b0;
                link_ready_d = 1'b1;
                ready_d      = 1'b1;
            end
            FAULT:   seq_error_d = 1'b1;
            default: ;
        endcase
    end

    assign sel_if.clk_sel_ready                 = ready_q;
    assign {sfp_mgt_clk_set1, sfp_mgt_clk_set0} = sel_cur;
    assign seq_state                            = state;
endmodule

// File: doc/clk_reset_sequencer.md
Name: clk_reset_sequencer

Overview:
- Power-up and recovery sequencer for the transmitter clocking block.
- Waits for a stable DCM lock, then pulses the GT reset and waits for GT PLL lock with timeout and bounded retries.
- Releases the transmit datapath reset once the link clocking is good.
- Owns the SFP MGT reference-clock source select bits. Source changes use a valid/ready request, followed by a full GT re-reset.

Parameters:
LOCK_STABLE_CYCLES, 1024, cycles dcm_locked must stay high before GT reset is issued
GT_RESET_CYCLES, 16, width of the gt_reset pulse in cycles
GT_LOCK_TIMEOUT, 65535, cycles spent in WAIT_GT before a retry
MAX_RETRIES, 3, GT lock attempts before FAULT
CLK_SET_DEFAULT, 2'b00, reset value of {sfp_mgt_clk_set1, sfp_mgt_clk_set0}

Ports:
drp_and_sys_clk  in  1  single system/DRP clock (60 MHz)
g_reset  in  1  global reset, synchronous, active-high
dcm_locked  in  1  DCM lock, asynchronous
gt_pll_locked  in  1  GT PLL lock, asynchronous
clk_sel_valid  in  1  clock-source change request
clk_sel  in  2  requested {set1,set0}
clk_sel_ready  out  1  request accepted when valid&ready
sfp_mgt_clk_set0  out  1  GTREFCLK source select bit 0
sfp_mgt_clk_set1  out  1  GTREFCLK source select bit 1
gt_reset  out  1  GT reset, active-high
tx_reset  out  1  transmit datapath reset, active-high
link_ready  out  1  clocking up, datapath running
seq_error  out  1  sticky fault
seq_state  out  3  current state encoding

Behaviour:
- Input synchronisation:
  - dcm_locked and gt_pll_locked each pass through a 2-flop synchroniser to give dcm_s and gt_s.
  - Only dcm_s and gt_s are used internally.
- Registered outputs:
  - All outputs are registered and change on the same edge as the state.
- Reset (g_reset=1 at a clock edge):
  - state=WAIT_DCM.
  - {set1,set0}=CLK_SET_DEFAULT.
  - gt_reset=1, tx_reset=1.
  - link_ready=0, seq_error=0, clk_sel_ready=0.
  - cnt=0, retry_cnt=0, synchronisers cleared.
  - A reset mid-operation restarts the whole sequence.
- States, by seq_state encoding:
  - 0 WAIT_DCM: gt_reset=1, tx_reset=1. Go to DCM_STABLE when dcm_s=1; cnt=0.
  - 1 DCM_STABLE: cnt increments. If dcm_s=0, go to WAIT_DCM. After exactly LOCK_STABLE_CYCLES cycles in this state, go to GT_RST.
  - 2 GT_RST: gt_reset=1 for exactly GT_RESET_CYCLES cycles, then go to WAIT_GT with cnt=0.
  - 3 WAIT_GT: gt_reset=0, tx_reset=1.
    - If gt_s=1, go to RUN.
    - When cnt reaches GT_LOCK_TIMEOUT-1 without lock, increment retry_cnt.
    - If the new retry_cnt equals MAX_RETRIES, go to FAULT; otherwise go to GT_RST.
  - 4 RUN: tx_reset=0, link_ready=1, clk_sel_ready=1; retry_cnt cleared on entry.
    - If gt_s=0, go to GT_RST (counts as a retry).
    - On clk_sel_valid&clk_sel_ready: latch clk_sel. If it differs from the current select, go to RECONFIG; if it is equal, accept the request and stay in RUN.
  - 5 RECONFIG: exactly one cycle.
    - link_ready=0, tx_reset=1, gt_reset=1, clk_sel_ready=0.
    - {set1,set0} takes the latched value on entry to this state.
    - Then go to GT_RST.
  - 6 FAULT: gt_reset=1, tx_reset=1, seq_error=1. Exit only via g_reset; dcm_s is ignored.
- Priority: g_reset, then dcm_s=0 (from DCM_STABLE..RECONFIG go to WAIT_DCM), then all other transitions.
- clk_sel_ready is 1 only while state=RUN. Requests made outside RUN are held off, not dropped, by the valid/ready rule.
- Select bits change only in RECONFIG or on reset; they never glitch during GT_RST or WAIT_GT.
- Counters are 17 bits wide, saturate, and never wrap.

Test Plan:
Use LOCK_STABLE_CYCLES=8, GT_RESET_CYCLES=4, GT_LOCK_TIMEOUT=20, MAX_RETRIES=2; edge 1 is the first edge that samples dcm_locked=1.
- Nominal bring-up: g_reset high for 5 cycles, then dcm_locked=1 at edge 1 and gt_pll_locked=1 from the start -> seq_state goes 0,1 at edge 3, 2 at edge 11, 3 at edge 15 with gt_reset=0, 4 at edge 18 with link_ready=1 and tx_reset=0.
- DCM glitch: dcm_locked drops for 3 cycles during DCM_STABLE -> return to WAIT_DCM; the stable count restarts from 0 after relock, and gt_reset stays 1 throughout.
- GT timeout: gt_pll_locked=0 always -> two gt_reset pulses of 4 cycles each separated by 20-cycle WAIT_GT windows, then seq_state=6 and seq_error=1. FAULT holds with dcm toggling and clears only after g_reset.
- Clock reselect: in RUN, clk_sel=2'b10 with valid for 1 cycle -> ready=1 handshake, one RECONFIG cycle, sfp_mgt_clk_set1=1 and set0=0, a 4-cycle gt_reset pulse, and link_ready back to 1 after relock. Same value 2'b00 -> accepted with no state change.
- Lock loss in RUN: gt_pll_locked falls -> GT_RST within 3 cycles (synchroniser plus 1) and tx_reset=1. dcm_locked falling on the same cycle as gt_pll_locked -> WAIT_DCM wins.
- Mid-sequence reset: g_reset asserted in WAIT_GT -> next edge gives all outputs at their reset values and {set1,set0}=CLK_SET_DEFAULT.
